hum_bcd: RTL and testbench

Sequential binary-to-BCD converter that sits directly downstream of the humidity scaling stage. It takes the 16-bit binary humidity word and produces packed BCD digits for the TM1638 display driver. Conversion uses shift-and-add-3 (double dabble), one bit per clock, under a start/busy/done handshake. The result register holds the last completed value, so the display driver always reads a stable number.

---
 rtl/hum_bcd.sv | 116 +++++++++++
 tb/tb_hum_bcd.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hum_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) with start/busy/done handshake.
// Optional leading-zero blanking (4'hF nibbles) enabled by defining HUM_BCD_LZB_EN.
module hum_bcd #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int unsigned SW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin_q, bin_nxt;
  logic [SW-1:0]    scr_q, scr_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             busy_nxt, done_nxt;
  logic [SW-1:0]    bcd_nxt;
  logic [SW-1:0]    adj;

  // Per-nibble +3 correction; 4-bit adds, no inter-nibble carry.
  function automatic logic [SW-1:0] add3(input logic [SW-1:0] s);
    logic [SW-1:0] r;
    r = s;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (s[4*i +: 4] >= 4'd5) r[4*i +: 4] = s[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

`ifdef HUM_BCD_LZB_EN
  // Replace leading zero digits with 4'hF; digit 0 always shown.
  function automatic logic [SW-1:0] publish(input logic [SW-1:0] v);
    logic [SW-1:0] r;
    logic          lead;
    r    = v;
    lead = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'h0)) r[4*i +: 4] = 4'hF;
      else                                lead = 1'b0;
    end
    return r;
  endfunction
`else
  function automatic logic [SW-1:0] publish(input logic [SW-1:0] v);
    return v;
  endfunction
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bin_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
    end else begin
      state   <= state_nxt;
      bin_q   <= bin_nxt;
      scr_q   <= scr_nxt;
      cnt_q   <= cnt_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      bcd_out <= bcd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_q;
    scr_nxt   = scr_q;
    cnt_nxt   = cnt_q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    bcd_nxt   = bcd_out;
    adj       = add3(scr_q);
    case (state)
      IDLE: begin
        if (start) begin
          bin_nxt   = bin_in;
          scr_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        {scr_nxt, bin_nxt} = {adj[SW-2:0], bin_q, 1'b0};
        cnt_nxt            = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_nxt = DONE;
      end
      DONE: begin
        bcd_nxt   = publish(scr_q);
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hum_bcd.sv
// Self-checking bench for hum_bcd: decimal-digit reference model checked every cycle plus directed literals.
// Expectations follow HUM_BCD_LZB_EN when the bench is built with it.
module tb_hum_bcd;

  localparam int unsigned W = 16;
  localparam int unsigned D = 5;
`ifdef HUM_BCD_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   bin_in = '0;
  logic           busy, done;
  logic [4*D-1:0] bcd_out;

  hum_bcd #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Decimal digits by division; digits above the value's decimal length are blanked when enabled.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    int unsigned p = 1;
    int          nd = 1;
    logic [19:0] r = '0;
    for (int unsigned t = v; t >= 10; t = t / 10) nd++;
    for (int d = 0; d < 5; d++) begin
      if (LZB && d >= nd) r[4*d +: 4] = 4'hF;
      else                r[4*d +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Timing model: k = edges since accept; publish at W+1, idle again (and re-acceptable) at W+2.
  bit          m_active = 1'b0;
  int          m_k = 0;
  logic [W-1:0] m_val = '0;
  logic        m_busy = 1'b0, m_done = 1'b0;
  logic [19:0] m_bcd = '0;
  int          m_accepts = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0; m_k = 0; m_busy = 1'b0; m_done = 1'b0; m_bcd = '0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        m_k++;
        if (m_k == W + 1) begin
          m_done = 1'b1; m_bcd = ref_bcd(32'(m_val)); m_busy = 1'b0;
        end
        if (m_k == W + 2) m_active = 1'b0;
      end
      if (!m_active && start) begin
        m_active = 1'b1; m_k = 0; m_busy = 1'b1; m_val = bin_in; m_accepts++;
      end
    end
  end

  bit cmp_en = 1'b0;
  int dut_dones = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("bcd_out", 32'(bcd_out), 32'(m_bcd));
      if (done) dut_dones++;
    end
  end

  // Called #1 after the accept edge; counts edges to done and busy-high cycles.
  task automatic wait_done(input string name, output int lat, output int bcnt);
    bit seen = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    if (!seen) check({name, "_timeout"}, 32'(lat), 32'(W + 1));
  endtask

  task automatic convert(input logic [W-1:0] v, input logic [19:0] exp, input string name);
    int lat, bcnt;
    @(negedge clk); start = 1'b1; bin_in = v;
    @(posedge clk); #1; start = 1'b0;
    wait_done(name, lat, bcnt);
    check({name, "_latency"}, 32'(lat), 32'd17);
    check({name, "_busy_cycles"}, 32'(bcnt), 32'd17);
    check({name, "_bcd"}, 32'(bcd_out), 32'(exp));
  endtask

  initial begin
    int lat, bcnt, ndone, k1, k2, k3, issued, d0;

    repeat (3) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_bcd", 32'(bcd_out), 32'd0);
    rst = 1'b1;
    cmp_en = 1'b1;

    // Zero, small and full-scale values.
    convert(16'd0,     LZB ? 20'hFFFF0 : 20'h00000, "zero");
    convert(16'd100,   LZB ? 20'hFF100 : 20'h00100, "v100");
    convert(16'd65535, 20'h65535, "v65535");

    // bin_in change and start pulse during conversion are ignored.
    @(negedge clk); start = 1'b1; bin_in = 16'd42;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1; bin_in = 16'd77;
    repeat (2) @(posedge clk);
    #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("ignore_done_count", 32'(ndone), 32'd1);
    check("ignore_bcd", 32'(bcd_out), LZB ? 32'h000FFF42 : 32'h00000042);

    // start held high: back-to-back conversions every W+2 cycles.
    @(negedge clk); start = 1'b1; bin_in = 16'd1234;
    @(posedge clk); #1;
    k1 = 0; k2 = 0; k3 = 0; ndone = 0;
    for (int k = 1; k <= 53; k++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) k1 = k; else if (ndone == 2) k2 = k; else k3 = k;
      end
    end
    start = 1'b0;
    check("hold_done_count", 32'(ndone), 32'd3);
    check("hold_done1_edge", 32'(k1), 32'd17);
    check("hold_done2_edge", 32'(k2), 32'd35);
    check("hold_done3_edge", 32'(k3), 32'd53);
    check("hold_bcd", 32'(bcd_out), LZB ? 32'h000F1234 : 32'h00001234);

    // Reset in the middle of a conversion.
    convert(16'd5678, LZB ? 20'hF5678 : 20'h05678, "v5678");
    @(negedge clk); start = 1'b1; bin_in = 16'd999;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2; rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd_out), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("postrst_no_done", 32'(ndone), 32'd0);
    convert(16'd999, LZB ? 20'hFF999 : 20'h00999, "v999");

    // Strided sweep; values checked by the per-cycle compare against the model.
    issued = 0;
    d0 = dut_dones;
    for (int v = 0; v <= 65535; v += 37) begin
      @(negedge clk); start = 1'b1; bin_in = W'(v);
      @(posedge clk); #1; start = 1'b0;
      issued++;
      wait_done("sweep", lat, bcnt);
    end
    @(negedge clk); start = 1'b1; bin_in = 16'hFFFF;
    @(posedge clk); #1; start = 1'b0;
    issued++;
    wait_done("sweep_last", lat, bcnt);
    @(negedge clk);
    check("sweep_done_count", 32'(dut_dones - d0), 32'(issued));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
